bfu_pipe: RTL and testbench
===========================

BFU_PIPE -- requirements
Module: bfu_pipe

Interface
REQ-001 SHALL have parameter DW, default 32: data width of a, b, w, c, d.
REQ-002 SHALL have parameter Q, default 8380417: modulus, odd, Q < 2^(DW-1).
REQ-003 SHALL have parameter LAT, default 6, range 6..8: input-accept to out_valid latency in cycles; stages beyond 6 are extra output register slices.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: the a/b/w/mode operand set is valid.
REQ-007 SHALL have port in_ready, output, 1: the pipeline accepts an operand set this cycle.
REQ-008 SHALL have port mode, input, 2: 00 CT-NTT; 01 GS-INTT; 10 bypass; 11 pointwise multiply.
REQ-009 SHALL have ports a, b, input, DW: operands, each in [0,Q).
REQ-010 SHALL have port w, input, DW: twiddle in Montgomery form (w'·2^DW mod Q), in [0,Q).
REQ-011 SHALL have port out_valid, output, 1: c/d hold a result.
REQ-012 SHALL have port out_ready, input, 1: the downstream consumer takes the result.
REQ-013 SHALL have ports c, d, output, DW: results.

Function
REQ-014 SHALL accept an operand set on a cycle where in_valid && in_ready is true.
REQ-015 SHALL define adv = !out_valid || out_ready; all stages advance only when adv is true, and in_ready = adv.
REQ-016 SHALL carry a per-stage valid bit, so a bubble occupies a stage and consumes no output slot.
REQ-017 SHALL produce each accepted set exactly LAT cycles after acceptance when out_ready is held high, i.e. throughput of one set per cycle.
REQ-018 SHALL hold c, d and out_valid stable while out_valid && !out_ready, with no loss, duplication or reordering.
REQ-019 SHALL compute mode 00 as t = b·w', c = (a+t) mod Q, d = (a−t) mod Q.
REQ-020 SHALL compute mode 01 as c = (a+b) mod Q, d = ((a−b) mod Q)·w' mod Q.
REQ-021 SHALL compute mode 10 as c = a, d = b, with the same LAT and handshake as the other modes.
REQ-022 SHALL compute mode 11 as c = a·w' mod Q, d = b·w' mod Q, using both multipliers.
REQ-023 SHALL implement all products as 2·DW-bit multiplies followed by Montgomery reduction with R = 2^DW.
REQ-024 SHALL implement modular add and subtract as one conditional ±Q correction each.
REQ-025 SHALL deliver every non-bypass output fully reduced into [0,Q); this covers the wrap boundaries a+b = Q and a−b = 0.
REQ-026 SHALL pipeline mode with the data, so a mode change between consecutive sets needs no flush.
REQ-027 SHALL leave outputs undefined, with no other effect, when operands are ≥ Q.

Reset
REQ-028 SHALL clear all stage valid bits on rst, with out_valid=0 and c=d=0 on the cycle after rst is sampled high.
REQ-029 SHALL discard in-flight sets when rst is asserted mid-operation; none appear after reset.
REQ-030 SHALL drive in_ready=1 during and after reset, since out_valid=0.

Configuration
REQ-031 SHALL, when BFU_HALF_INTT_EN is defined, multiply both mode-01 outputs by 2^-1 mod Q (x even → x/2; x odd → (x+Q)/2) within the same LAT.
REQ-032 SHALL, when BFU_HALF_INTT_EN is undefined, produce mode-01 outputs unscaled and omit the halving logic; modes 00, 10 and 11 are unaffected by the macro.

Structure
REQ-033 SHALL take from shared package bfu_pkg: the mode encoding constants, Q_DEFAULT, the function deriving QINV = −Q^-1 mod 2^DW, and R mod Q.
REQ-034 SHALL instantiate sub-module bfu_mont_red (2·DW-bit in, DW-bit in [0,Q) out, 2 internal register stages) twice.
REQ-035 SHALL keep the handshake/valid-chain logic in bfu_pipe itself.

Verification (Q=8380417, DW=32, wR = 2^32 mod Q = 4193792, i.e. w'=1)
REQ-036 SHALL cover mode 00, a=5, b=7, w=wR -> c=12, d=8380415 after 6 cycles; and a=8380416, b=1, w=wR -> c=0, d=8380415.
REQ-037 SHALL cover mode 01, a=5, b=7, w=wR -> c=12, d=8380415; with BFU_HALF_INTT_EN -> c=6, d=8380416.
REQ-038 SHALL cover mode 10, a=3, b=4 -> c=3, d=4; and mode 11, a=2, b=3, w=2·wR mod Q -> c=4, d=6.
REQ-039 SHALL cover back-to-back sets with mixed modes on consecutive cycles and out_ready tied high -> one result per cycle, correct per-set mode, in order.
REQ-040 SHALL cover out_ready low for 10 cycles while 12 sets are offered -> in_ready falls, c/d are held, and all 12 results arrive in order with none lost or duplicated.
REQ-041 SHALL cover rst pulsed for one cycle with 4 sets in flight -> out_valid=0 the next cycle and no stale result afterwards.

Source files
------------

// File: rtl/bfu_pkg.sv
// bfu_pkg: butterfly mode encodings, default modulus and Montgomery constant helpers
// shared by bfu_pipe and bfu_mont_red.
package bfu_pkg;

  typedef enum logic [1:0] {
    MODE_CT  = 2'b00,
    MODE_GS  = 2'b01,
    MODE_BYP = 2'b10,
    MODE_PWM = 2'b11
  } bfu_mode_e;

  localparam int Q_DEFAULT = 32'sd8380417;

  // -Q^-1 mod 2^dw by Newton iteration; an odd q is its own inverse to 3 bits.
  function automatic logic [63:0] mont_qinv(input int unsigned q, input int unsigned dw);
    logic [63:0] inv;
    logic [63:0] qq;
    logic [63:0] mask;
    qq  = 64'(q);
    inv = qq;
    for (int i = 0; i < 6; i++) begin
      inv = inv * (64'd2 - qq * inv);
    end
    mask = (dw >= 32'd64) ? {64{1'b1}} : ((64'd1 << dw) - 64'd1);
    return (64'd0 - inv) & mask;
  endfunction

  function automatic logic [63:0] r_mod_q(input int unsigned q, input int unsigned dw);
    logic [64:0] r;
    r = 65'd1 << dw;
    return 64'(r % 65'(q));
  endfunction

endpackage

// File: rtl/bfu_mont_red.sv
// bfu_mont_red: two-stage Montgomery reduction with R = 2^DW. The input must be
// below Q*R; the registered output is fully reduced into [0,Q).
module bfu_mont_red
  import bfu_pkg::*;
#(
  parameter int DW = 32,
  parameter int Q  = Q_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [2*DW-1:0] i_t,
  output logic [DW-1:0]   o_r
);

  localparam logic [DW-1:0] QINV = DW'(mont_qinv(Q, DW));
  localparam logic [DW-1:0] Q_D  = DW'(Q);

  logic [2*DW-1:0] r_t;
  logic [DW-1:0]   r_m;
  logic [DW-1:0]   w_m;
  logic [2*DW:0]   w_mq;
  logic [DW:0]     w_u;

  // T + m*Q is a multiple of R, so the quotient is exact and below 2Q.
  assign w_m  = i_t[DW-1:0] * QINV;
  assign w_mq = (2*DW+1)'(r_m) * (2*DW+1)'(Q_D);
  assign w_u  = (DW+1)'(({1'b0, r_t} + w_mq) >> DW);

  // Stage 1 holds T and m, stage 2 holds the corrected quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t <= {(2*DW){1'b0}};
      r_m <= {DW{1'b0}};
      o_r <= {DW{1'b0}};
    end else if (i_en) begin
      r_t <= i_t;
      r_m <= w_m;
      o_r <= (w_u >= {1'b0, Q_D}) ? DW'(w_u - {1'b0, Q_D}) : w_u[DW-1:0];
    end
  end

endmodule

// File: rtl/bfu_pipe.sv
// bfu_pipe: pipelined CT/GS butterfly, bypass and pointwise multiply with valid/ready flow.
// Define BFU_HALF_INTT_EN to scale both GS-INTT outputs by 2^-1 mod Q.
module bfu_pipe
  import bfu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int Q   = Q_DEFAULT,
  parameter int LAT = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] c,
  output logic [DW-1:0] d
);

  localparam int            NOUT = LAT - 5;
  localparam logic [DW-1:0] Q_D  = DW'(Q);
  localparam logic [DW:0]   Q_X  = (DW+1)'(Q);

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= Q_X) ? DW'(s - Q_X) : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return (x - y) + ((x < y) ? Q_D : {DW{1'b0}});
  endfunction

`ifdef BFU_HALF_INTT_EN
  function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x);
    logic [DW:0] h;
    h = {1'b0, x} + (x[0] ? Q_X : {(DW+1){1'b0}});
    return DW'(h >> 1);
  endfunction
`endif

  logic            w_adv;
  logic            r1_v, r2_v, r3_v, r4_v, r5_v;
  bfu_mode_e       r1_mode, r2_mode, r3_mode, r4_mode, r5_mode;
  logic [DW-1:0]   r1_a, r1_b, r1_w;
  logic [DW-1:0]   r2_a, r2_b, r2_w, r2_add, r2_sub;
  logic [DW-1:0]   r3_x, r3_y, r4_x, r4_y, r5_x, r5_y;
  logic [2*DW-1:0] r3_p0, r3_p1;
  logic [DW-1:0]   w_op0, w_t0, w_t1, w_c, w_d;
  logic [NOUT-1:0] r_ov;
  logic [DW-1:0]   r_oc [NOUT];
  logic [DW-1:0]   r_od [NOUT];

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_ov[NOUT-1];
  assign c         = r_oc[NOUT-1];
  assign d         = r_od[NOUT-1];

  // Multiplier-0 operand: b for CT, the a-b difference for GS, a for pointwise.
  always_comb begin
    w_op0 = r2_b;
    case (r2_mode)
      MODE_GS:  w_op0 = r2_sub;
      MODE_PWM: w_op0 = r2_a;
      default:  w_op0 = r2_b;
    endcase
  end

  // Operand, add/sub and product stages plus the sidecar riding beside the reducers.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r1_v, r2_v, r3_v, r4_v, r5_v} <= 5'b00000;
      {r1_mode, r2_mode, r3_mode, r4_mode, r5_mode} <= {5{MODE_CT}};
      {r1_a, r1_b, r1_w} <= {(3*DW){1'b0}};
      {r2_a, r2_b, r2_w, r2_add, r2_sub} <= {(5*DW){1'b0}};
      {r3_x, r3_y, r4_x, r4_y, r5_x, r5_y} <= {(6*DW){1'b0}};
      {r3_p0, r3_p1} <= {(4*DW){1'b0}};
    end else if (w_adv) begin
      r1_v    <= in_valid;
      r1_mode <= bfu_mode_e'(mode);
      r1_a    <= a;
      r1_b    <= b;
      r1_w    <= w;
      r2_v    <= r1_v;
      r2_mode <= r1_mode;
      r2_a    <= r1_a;
      r2_b    <= r1_b;
      r2_w    <= r1_w;
      r2_add  <= mod_add(r1_a, r1_b);
      r2_sub  <= mod_sub(r1_a, r1_b);
      r3_v    <= r2_v;
      r3_mode <= r2_mode;
      r3_x    <= r2_a;
      r3_y    <= (r2_mode == MODE_GS) ? r2_add : r2_b;
      r3_p0   <= (2*DW)'(w_op0) * (2*DW)'(r2_w);
      r3_p1   <= (2*DW)'(r2_b) * (2*DW)'(r2_w);
      {r4_v, r4_mode, r4_x, r4_y} <= {r3_v, r3_mode, r3_x, r3_y};
      {r5_v, r5_mode, r5_x, r5_y} <= {r4_v, r4_mode, r4_x, r4_y};
    end
  end

  bfu_mont_red #(.DW(DW), .Q(Q)) u_red0 (
    .clk (clk),
    .rst (rst),
    .i_en(w_adv),
    .i_t (r3_p0),
    .o_r (w_t0)
  );

  bfu_mont_red #(.DW(DW), .Q(Q)) u_red1 (
    .clk (clk),
    .rst (rst),
    .i_en(w_adv),
    .i_t (r3_p1),
    .o_r (w_t1)
  );

  // Final butterfly combine per the mode carried alongside the data.
  always_comb begin
    w_c = r5_x;
    w_d = r5_y;
    case (r5_mode)
      MODE_CT: begin
        w_c = mod_add(r5_x, w_t0);
        w_d = mod_sub(r5_x, w_t0);
      end
      MODE_GS: begin
`ifdef BFU_HALF_INTT_EN
        w_c = mod_half(r5_y);
        w_d = mod_half(w_t0);
`else
        w_c = r5_y;
        w_d = w_t0;
`endif
      end
      MODE_PWM: begin
        w_c = w_t0;
        w_d = w_t1;
      end
      default: begin
        w_c = r5_x;
        w_d = r5_y;
      end
    endcase
  end

  // Output register plus LAT-6 extra slices.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov <= {NOUT{1'b0}};
      for (int i = 0; i < NOUT; i++) begin
        r_oc[i] <= {DW{1'b0}};
        r_od[i] <= {DW{1'b0}};
      end
    end else if (w_adv) begin
      r_ov[0] <= r5_v;
      r_oc[0] <= w_c;
      r_od[0] <= w_d;
      for (int i = 1; i < NOUT; i++) begin
        r_ov[i] <= r_ov[i-1];
        r_oc[i] <= r_oc[i-1];
        r_od[i] <= r_od[i-1];
      end
    end
  end

endmodule

// File: tb/tb_bfu_pipe.sv
// tb_bfu_pipe: directed vectors with a scoreboard queue and an independent output monitor.
// Expected values follow BFU_HALF_INTT_EN when the bench is built with it defined.
module tb_bfu_pipe;
  import bfu_pkg::*;

  localparam int          DW  = 32;
  localparam int          Q   = 8380417;
  localparam int          LAT = 6;
  localparam logic [31:0] WR  = 32'd4193792;
  localparam logic [31:0] W2  = 32'd7167;
`ifdef BFU_HALF_INTT_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  mode;
  logic [31:0] a, b, w, c, d;

  always #5 clk = ~clk;

  bfu_pipe #(.DW(DW), .Q(Q), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .w(w), .out_valid(out_valid), .out_ready(out_ready), .c(c), .d(d)
  );

  typedef struct { logic [1:0] m; logic [31:0] a, b, w, c, d; } vec_t;
  typedef struct { logic [31:0] c, d; int t; bit lat; int id; } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [1:0] m, input logic [31:0] a_, input logic [31:0] b_,
                              input logic [31:0] w_, input logic [31:0] c_, input logic [31:0] d_);
    vec_t v;
    v.m = m; v.a = a_; v.b = b_; v.w = w_; v.c = c_; v.d = d_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the set is accepted.
  task automatic offer(input int idx, input bit lat);
    bit   done;
    exp_t e;
    done = 1'b0;
    in_valid = 1'b1;
    mode = vecs[idx].m; a = vecs[idx].a; b = vecs[idx].b; w = vecs[idx].w;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e.c = vecs[idx].c; e.d = vecs[idx].d; e.t = cyc; e.lat = lat; e.id = idx;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout vec %0d: in_ready stayed low, expected 1", idx);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops on every transfer, and checks outputs hold steady while stalled.
  initial begin
    bit          held;
    logic [31:0] hc, hd;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        held = 1'b0;
      end else begin
        if (held) begin
          n_cmp++;
          if (out_valid !== 1'b1 || c !== hc || d !== hd) begin
            n_fail++;
            $display("FAIL hold: valid=%0b c=%0d d=%0d, expected valid=1 c=%0d d=%0d",
                     out_valid, c, d, hc, hd);
          end
        end
        if (out_valid === 1'b1) begin
          held = (out_ready !== 1'b1);
          hc = c; hd = d;
          if (out_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_output: c=%0d d=%0d, expected no output", c, d);
            end else begin
              e = sb.pop_front();
              if (c !== e.c || d !== e.d) begin
                n_fail++;
                $display("FAIL result vec %0d: c=%0d d=%0d, expected c=%0d d=%0d",
                         e.id, c, d, e.c, e.d);
              end
              if (e.lat) begin
                n_cmp++;
                if (cyc - e.t != LAT) begin
                  n_fail++;
                  $display("FAIL latency vec %0d: %0d cycles, expected %0d", e.id, cyc - e.t, LAT);
                end
              end
            end
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rq;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00;
    a = 32'd0; b = 32'd0; w = 32'd0;
    vecs[0]  = mk(2'b00, 32'd5, 32'd7, WR, 32'd12, 32'd8380415);
    vecs[1]  = mk(2'b00, 32'd8380416, 32'd1, WR, 32'd0, 32'd8380415);
    vecs[2]  = mk(2'b01, 32'd5, 32'd7, WR, HALF ? 32'd6 : 32'd12, HALF ? 32'd8380416 : 32'd8380415);
    vecs[3]  = mk(2'b10, 32'd3, 32'd4, 32'd99, 32'd3, 32'd4);
    vecs[4]  = mk(2'b11, 32'd2, 32'd3, W2, 32'd4, 32'd6);
    vecs[5]  = mk(2'b00, 32'd100, 32'd50, W2, 32'd200, 32'd0);
    vecs[6]  = mk(2'b01, 32'd9, 32'd9, WR, HALF ? 32'd9 : 32'd18, 32'd0);
    vecs[7]  = mk(2'b01, 32'd8380410, 32'd7, WR, 32'd0, HALF ? 32'd8380410 : 32'd8380403);
    vecs[8]  = mk(2'b11, 32'd123456, 32'd8380416, WR, 32'd123456, 32'd8380416);
    vecs[9]  = mk(2'b00, 32'd5, 32'd7, 32'd0, 32'd5, 32'd5);
    vecs[10] = mk(2'b01, 32'd1, 32'd2, W2, HALF ? 32'd4190210 : 32'd3, HALF ? 32'd8380416 : 32'd8380415);
    vecs[11] = mk(2'b10, 32'd8380416, 32'd0, WR, 32'd8380416, 32'd0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_c", c, 32'd0);
    chk("reset_d", d, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rq = r_mod_q(Q, DW);
    chk("pkg_r_mod_q", rq[31:0], WR);
    @(posedge clk); #1;

    // Isolated sets with exact latency.
    for (int i = 0; i < 5; i++) begin
      offer(i, 1'b1);
      idle(8);
    end

    // Back-to-back mixed modes, one per cycle.
    for (int i = 0; i < 12; i++) offer(i, 1'b1);
    idle(10);

    // Downstream stall of 10 cycles while 12 sets are offered.
    fork
      begin
        for (int i = 0; i < 12; i++) offer(11 - i, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    idle(2);

    // Reset pulse with four sets in flight.
    for (int i = 4; i < 8; i++) offer(i, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pulse_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pulse_c", c, 32'd0);
    chk("rst_pulse_d", d, 32'd0);
    chk("rst_pulse_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_reset_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    offer(7, 1'b1);
    offer(10, 1'b1);
    idle(10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
